// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, assembles each big-endian word from
// four byte reads of imem and hands it to decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter int          ADDR_W    = 8,
  parameter int          MEM_BYTES = 150,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [31:0]       ins_word,
  output logic [31:0]       ins_pc,
  output logic [31:0]       pc_plus4,
  output logic              fault
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, CAP, VALID, FAULT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d, pc_inc;
  logic [23:0]       bytes_q;
  logic [ADDR_W-1:0] addr_off;
  logic              load_addr;

  // Word fetch must be aligned and its last byte inside imem; 33-bit sum so a
  // PC near 2^32 cannot wrap back into range.
  function automatic logic legal(input logic [31:0] p);
    logic [32:0] last;
    last = {1'b0, p} + 33'd3;
    return (p[1:0] == 2'b00) && (last < 33'(MEM_BYTES));
  endfunction

  assign pc_inc = pc_q + 32'd4;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
      if (!legal(redirect_pc)) state_d = FAULT;
      else if (en)             state_d = RD0;
      else                     state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (en) state_d = legal(pc_q) ? RD0 : FAULT;
        RD0:   state_d = RD1;
        RD1:   state_d = RD2;
        RD2:   state_d = RD3;
        RD3:   state_d = CAP;
        CAP:   state_d = VALID;
        VALID: if (ins_ready) begin
                 pc_d = pc_inc;
                 if (en) state_d = legal(pc_inc) ? RD0 : FAULT;
                 else    state_d = IDLE;
               end
        FAULT: state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Address for the read issued in the upcoming cycle; held when no read follows.
  always_comb begin
    load_addr = 1'b1;
    case (state_d)
      RD0:     addr_off = ADDR_W'(0);
      RD1:     addr_off = ADDR_W'(1);
      RD2:     addr_off = ADDR_W'(2);
      RD3:     addr_off = ADDR_W'(3);
      default: begin
        addr_off  = ADDR_W'(0);
        load_addr = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      mem_addr <= '0;
      bytes_q  <= '0;
      ins_word <= '0;
      ins_pc   <= '0;
      pc_plus4 <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (load_addr) mem_addr <= pc_d[ADDR_W-1:0] + addr_off;
      // Bytes arrive one cycle after their read: byte0 lands during RD1.
      if (!redirect && (state_q == RD1 || state_q == RD2 || state_q == RD3))
        bytes_q <= {bytes_q[15:0], mem_data};
      if (!redirect && state_q == CAP) begin
        ins_word <= {bytes_q, mem_data};
        ins_pc   <= pc_q;
        pc_plus4 <= pc_inc;
      end
    end
  end

  assign mem_rd    = (state_q == RD0) || (state_q == RD1) ||
                     (state_q == RD2) || (state_q == RD3);
  assign ins_valid = (state_q == VALID);
  assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte-wide imem model, directed stimulus, and a
// scoreboard monitor that checks every word decode accepts.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_word;
  logic [31:0] ins_pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [0:149];

  fetch_sequencer #(.ADDR_W(8), .MEM_BYTES(150), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_word(ins_word), .ins_pc(ins_pc), .pc_plus4(pc_plus4), .fault(fault)
  );

  always #5 clk = ~clk;

  // imem: data for a read strobe appears one cycle later
  always @(posedge clk) begin
    int idx;
    idx = int'(mem_addr);
    if (mem_rd) mem_data <= (idx < 150) ? mem[idx] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    e.word = w;
    e.pc   = p;
    sb.push_back(e);
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!ins_valid && n < max) begin
      tick(1);
      n++;
    end
    check("valid_within_budget", {31'd0, ins_valid}, 32'd1);
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && ins_valid && ins_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got word %h at pc %h, none expected", ins_word, ins_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_word", ins_word, e.word);
        check("sb_pc", ins_pc, e.pc);
        check("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rd"},    {31'd0, mem_rd},    32'd0);
    check({tag, "_mem_addr"},  {24'd0, mem_addr},  32'd0);
    check({tag, "_ins_valid"}, {31'd0, ins_valid}, 32'd0);
    check({tag, "_ins_word"},  ins_word,           32'd0);
    check({tag, "_ins_pc"},    ins_pc,             32'd0);
    check({tag, "_pc_plus4"},  pc_plus4,           32'd0);
    check({tag, "_fault"},     {31'd0, fault},     32'd0);
  endtask

  initial begin
    for (int i = 0; i < 150; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
    mem[4] = 8'h21; mem[5] = 8'h29; mem[6] = 8'h00; mem[7] = 8'h01;

    rst_n = 1'b0; en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ins_ready = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // T1/T2: first word latency, then held for 10 cycles with ready low
    push(32'h2008_0005, 32'h0);
    push(32'h2129_0001, 32'h4);
    en = 1'b1;
    tick(1);
    check("rd0_mem_rd", {31'd0, mem_rd}, 32'd1);
    check("rd0_addr", {24'd0, mem_addr}, 32'h0);
    tick(4);
    check("cap_not_valid", {31'd0, ins_valid}, 32'd0);
    tick(1);
    check("latency_valid", {31'd0, ins_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", {31'd0, ins_valid}, 32'd1);
      check("hold_word", ins_word, 32'h2008_0005);
      check("hold_pc", ins_pc, 32'h0);
      check("hold_no_rd", {31'd0, mem_rd}, 32'd0);
      tick(1);
    end
    ins_ready = 1'b1;
    tick(1);
    check("next_rd0_addr", {24'd0, mem_addr}, 32'h4);
    check("next_rd0_rd", {31'd0, mem_rd}, 32'd1);

    // T6: drop en in RD3, word still delivered, then idle
    tick(3);
    check("rd3_addr", {24'd0, mem_addr}, 32'h7);
    en = 1'b0;
    tick(2);
    check("t6_valid", {31'd0, ins_valid}, 32'd1);
    tick(1);
    check("t6_idle_valid", {31'd0, ins_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("t6_idle_no_rd", {31'd0, mem_rd}, 32'd0);
      tick(1);
    end

    // T3: redirect during RD2 of the word at 8
    en = 1'b1;
    tick(3);
    check("rd2_addr", {24'd0, mem_addr}, 32'ha);
    push(32'hE3EA_F1F8, 32'h20);
    redirect = 1'b1; redirect_pc = 32'h20;
    tick(1);
    redirect = 1'b0; en = 1'b0;
    check("redir_addr", {24'd0, mem_addr}, 32'h20);
    check("redir_not_valid", {31'd0, ins_valid}, 32'd0);
    wait_valid(10);
    tick(1);

    // T4: misaligned redirect faults; legal redirect recovers
    redirect = 1'b1; redirect_pc = 32'h22; en = 1'b1;
    tick(1);
    redirect = 1'b0;
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_no_rd", {31'd0, mem_rd}, 32'd0);
    check("mis_no_valid", {31'd0, ins_valid}, 32'd0);
    tick(3);
    check("fault_sticky", {31'd0, fault}, 32'd1);
    push(32'h737A_8188, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h10;
    tick(1);
    redirect = 1'b0; en = 1'b0;
    check("recover_fault", {31'd0, fault}, 32'd0);
    check("recover_addr", {24'd0, mem_addr}, 32'h10);
    wait_valid(10);
    tick(1);

    // T4: sequential run off the end of imem
    push(32'hD7DE_E5EC, 32'd140);
    push(32'hF3FA_0108, 32'd144);
    redirect = 1'b1; redirect_pc = 32'd140; en = 1'b1;
    tick(1);
    redirect = 1'b0;
    for (int i = 0; i < 40 && !fault; i++) tick(1);
    check("end_fault", {31'd0, fault}, 32'd1);
    check("end_no_rd", {31'd0, mem_rd}, 32'd0);
    tick(3);
    check("end_still_fault", {31'd0, fault}, 32'd1);
    check("end_still_no_rd", {31'd0, mem_rd}, 32'd0);
    check("end_sb_empty", sb.size(), 32'd0);

    // T5: async reset during RD1
    redirect = 1'b1; redirect_pc = 32'h0;
    tick(1);
    redirect = 1'b0;
    tick(1);
    check("pre_rst_addr", {24'd0, mem_addr}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick(2);
    push(32'h2008_0005, 32'h0);
    rst_n = 1'b1;
    tick(1);
    check("restart_rd", {31'd0, mem_rd}, 32'd1);
    check("restart_addr", {24'd0, mem_addr}, 32'h0);
    en = 1'b0;
    wait_valid(10);
    tick(2);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
